// File: rtl/alu_seq_unit.sv
// alu_seq_unit: single-request ALU with a multi-cycle shifter.
// A request is accepted in IDLE. Non-shift ops, zero-distance shifts and illegal
// requests complete one cycle later. Shifts walk the captured operand by up to
// SHIFT_STEP bits per cycle in the SHIFT state. The result is held in DONE until
// the consumer takes it.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready only in IDLE)
//   aluOp, funct3,
//   funct7_5, is_rtype   operation select and instruction decode fields
//   op_a, op_b           operands; shift distance is op_b[log2(WIDTH)-1:0]
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   result, zero,
//   illegal              registered result and flags, meaningful with out_valid
module alu_seq_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluOp,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             is_rtype,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned LOG = $clog2(WIDTH);
    localparam logic [LOG-1:0] StepAmt = LOG'(SHIFT_STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [3:0] {
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd, OpIll
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d, op_dec;
    logic [WIDTH-1:0] work_q, work_d;
    logic [LOG-1:0]   rem_q, rem_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;

    logic [LOG-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] alu_res;
    logic [LOG-1:0]   step_amt;
    logic [LOG-1:0]   rem_next;
    logic [WIDTH-1:0] shifted;

    assign shamt    = op_b[LOG-1:0];
    assign is_shift = (op_dec == OpSll) || (op_dec == OpSrl) || (op_dec == OpSra);

    // Request decode
    always_comb begin
        op_dec = OpIll;
        unique case (aluOp)
            2'b00: op_dec = OpAdd;
            2'b01: op_dec = OpSub;
            2'b10: begin
                unique case (funct3)
                    3'b000:  op_dec = (is_rtype && funct7_5) ? OpSub : OpAdd;
                    3'b001:  op_dec = OpSll;
                    3'b010:  op_dec = OpSlt;
                    3'b011:  op_dec = OpSltu;
                    3'b100:  op_dec = OpXor;
                    3'b101:  op_dec = funct7_5 ? OpSra : OpSrl;
                    3'b110:  op_dec = OpOr;
                    default: op_dec = OpAnd;
                endcase
            end
            default: op_dec = OpIll;
        endcase
    end

    // Single-cycle results; shifts only land here when their distance is zero
    always_comb begin
        alu_res = '0;
        unique case (op_dec)
            OpAdd:  alu_res = op_a + op_b;
            OpSub:  alu_res = op_a - op_b;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OpXor:  alu_res = op_a ^ op_b;
            OpOr:   alu_res = op_a | op_b;
            OpAnd:  alu_res = op_a & op_b;
            OpSll, OpSrl, OpSra: alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    // One shifter step of min(SHIFT_STEP, remaining) bits
    always_comb begin
        step_amt = (rem_q > StepAmt) ? StepAmt : rem_q;
        rem_next = rem_q - step_amt;
        if (op_q == OpSll) begin
            shifted = work_q << step_amt;
        end else begin
            shifted = work_q >> step_amt;
            // SRA refills vacated bits with the sign captured at accept time
            if (op_q == OpSra && sign_q) begin
                shifted = shifted | ~({WIDTH{1'b1}} >> step_amt);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d   = op_dec;
                    sign_d = op_a[WIDTH-1];
                    ill_d  = (op_dec == OpIll);
                    if (is_shift && shamt != '0) begin
                        work_d  = op_a;
                        rem_d   = shamt;
                        state_d = StShift;
                    end else begin
                        work_d  = alu_res;
                        zero_d  = (alu_res == '0);
                        rem_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    zero_d  = (shifted == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            work_q  <= '0;
            rem_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = work_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit (WIDTH=32, SHIFT_STEP=4).
module tb_alu_seq_unit;

    localparam int W    = 32;
    localparam int STEP = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   aluOp;
    logic [2:0]   funct3;
    logic         funct7_5;
    logic         is_rtype;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    alu_seq_unit #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aluOp    (aluOp),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_rtype (is_rtype),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   ready_mode = 0;  // 0 random, 1 hold low, 2 hold high

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-operation arithmetic, latency from the shift distance
    function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                  input logic rt, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic il, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        il  = 1'b0;
        lat = 1;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd3: il = 1'b1;
            default: begin
                case (f3)
                    3'd0: r = (rt && f7) ? a - b : a + b;
                    3'd1: begin r = a << sh; lat = 1 + (sh + STEP - 1) / STEP; end
                    3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: r = (a < b) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: begin
                        r   = f7 ? W'($signed(a) >>> sh) : a >> sh;
                        lat = 1 + (sh + STEP - 1) / STEP;
                    end
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
        endcase
    endfunction

    // Scramble request inputs; used while the DUT is busy and right after accept
    task automatic junk();
        in_valid = 1'($urandom);
        aluOp    = 2'($urandom);
        funct3   = 3'($urandom);
        funct7_5 = 1'($urandom);
        is_rtype = 1'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Called at a negedge; waits for in_ready, then issues one request
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic rt, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string name, input bit push);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 500) begin
            junk();
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s: in_ready never rose (waited %0d cycles)", name, n);
            return;
        end
        in_valid = 1'b1;
        aluOp    = op;
        funct3   = f3;
        funct7_5 = f7;
        is_rtype = rt;
        op_a     = a;
        op_b     = b;
        if (push) begin
            model(op, f3, f7, rt, a, b, e.res, e.ill, e.lat);
            e.zero = (e.res == '0);
            e.acc  = cyc;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        junk();
        in_valid = 1'b0;
    endtask

    // Monitor: compares the presented result against the queue head every valid cycle
    bit seen = 1'b0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: out_valid with empty scoreboard, result 0x%08h",
                             result);
                    out_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        check({sb[0].name, " latency"}, W'(cyc - sb[0].acc), W'(sb[0].lat));
                        seen = 1'b1;
                    end
                    check({sb[0].name, " result"}, result, sb[0].res);
                    check({sb[0].name, " zero"}, W'(zero), W'(sb[0].zero));
                    check({sb[0].name, " illegal"}, W'(illegal), W'(sb[0].ill));
                    out_ready = (ready_mode == 1) ? 1'b0 :
                                (ready_mode == 2) ? 1'b1 : ($urandom_range(3) != 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                out_ready = (ready_mode == 1) ? 1'b0 : 1'($urandom);
            end
        end
    end

    task automatic check_idle_reset(input string name);
        check({name, " in_ready"}, W'(in_ready), W'(1));
        check({name, " out_valid"}, W'(out_valid), W'(0));
        check({name, " result"}, result, '0);
        check({name, " zero"}, W'(zero), W'(0));
        check({name, " illegal"}, W'(illegal), W'(0));
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        aluOp    = '0;
        funct3   = '0;
        funct7_5 = 1'b0;
        is_rtype = 1'b0;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(negedge clk);
        check_idle_reset("reset");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, "sub_r", 1'b1);
        issue(2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd31, "sra31", 1'b1);
        issue(2'b10, 3'b000, 1'b1, 1'b0, 32'd3, 32'd3, "addi", 1'b1);
        issue(2'b10, 3'b000, 1'b1, 1'b1, 32'd3, 32'd3, "sub_zero", 1'b1);
        issue(2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, "slt", 1'b1);
        issue(2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, "sltu", 1'b1);
        issue(2'b10, 3'b001, 1'b0, 1'b1, 32'h1234_5678, 32'h20, "sll0", 1'b1);
        issue(2'b10, 3'b101, 1'b0, 1'b1, 32'hF000_000F, 32'd7, "srl7", 1'b1);
        issue(2'b10, 3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'd31, "sll31", 1'b1);
        issue(2'b11, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, "illegal", 1'b1);

        // Back-pressure: result held while in_valid pulses and in_ready stays low
        ready_mode = 1;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd100, 32'd23, "hold", 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            junk();
            in_valid = 1'b1;
            check("hold in_ready", W'(in_ready), W'(0));
            @(negedge clk);
        end
        in_valid   = 1'b0;
        ready_mode = 2;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("release in_ready", W'(in_ready), W'(1));
        check("release out_valid", W'(out_valid), W'(0));
        ready_mode = 0;
        @(negedge clk);

        // Reset mid-shift aborts with no result, then an illegal request completes
        issue(2'b10, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd20, "sll20_abort", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_reset("abort");
        issue(2'b11, 3'b101, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd1, "illegal2", 1'b1);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            if ($urandom_range(4) == 0) a = '0;
            issue(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), a, b, "rand", 1'b1);
        end

        n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("drain pending", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 SHALL have parameter SHIFT_STEP, default 1, maximum shift distance applied per cycle; power of two, 1..WIDTH/2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port aluOp  input  2  00 ADD, 01 SUB, 10 funct-decoded, 11 illegal.
REQ-008 SHALL have port funct3  input  3  instruction funct3.
REQ-009 SHALL have port funct7_5  input  1  instruction bit 30.
REQ-010 SHALL have port is_rtype  input  1  1 = register-register op; gates SUB decode.
REQ-011 SHALL have port op_a, op_b  input  WIDTH each  operands; shift amount = op_b[log2(WIDTH)-1:0].
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  WIDTH  operation result.
REQ-015 SHALL have port zero  output  1  result == 0.
REQ-016 SHALL have port illegal  output  1  request decoded as illegal.

Function
REQ-017 Decode SHALL be: aluOp 00 ADD; 01 SUB; 10 by funct3: 000 SUB if is_rtype&funct7_5 else ADD, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRA if funct7_5 else SRL, 110 OR, 111 AND; 11 illegal.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; SLT/SLTU return 1 or 0 zero-extended to WIDTH.
REQ-019 Operands, decoded op and flags SHALL be captured on the cycle in_valid && in_ready; later input changes SHALL NOT affect the in-flight operation.
REQ-020 FSM SHALL have states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-021 IDLE: on accept of a non-shift op, or a shift with shift amount 0, -> DONE next cycle (latency 1); on a shift with amount > 0 -> SHIFT.
REQ-022 SHIFT: each cycle SHALL shift the working register by min(SHIFT_STEP, remaining) and decrement remaining by the same; -> DONE on the cycle remaining reaches 0; total latency 1 + ceil(shamt/SHIFT_STEP) cycles.
REQ-023 SRA SHALL replicate the captured op_a sign bit on every step; SRL/SLL SHALL fill with zeros.
REQ-024 DONE: result, zero and illegal SHALL hold stable until out_valid && out_ready; -> IDLE on that cycle; a new request is accepted no earlier than the following cycle.
REQ-025 Illegal request SHALL complete with latency 1, result = 0, zero = 1, illegal = 1.
REQ-026 in_valid while in_ready = 0 SHALL be ignored; no request is queued.
REQ-027 zero and illegal SHALL be registered together with result; they are meaningful only when out_valid = 1.

Reset
REQ-028 reset SHALL force state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, illegal = 0, remaining shift count = 0.
REQ-029 reset asserted in SHIFT or DONE SHALL abort the operation with no result delivered; reset has priority over all handshakes in the same cycle.

Verification
REQ-030 WIDTH=32: aluOp=10, funct3=000, is_rtype=1, funct7_5=1, a=5, b=7 -> out_valid 1 cycle after accept, result=0xFFFFFFFE, zero=0.
REQ-031 WIDTH=32, SHIFT_STEP=1: SRA a=0x80000000, b=31 -> in_ready low for 32 cycles, result=0xFFFFFFFF after 32-cycle latency; SHIFT_STEP=4 same stimulus -> latency 9.
REQ-032 aluOp=10, funct3=000, is_rtype=0, funct7_5=1, a=3, b=3 (ADDI) -> result=6; aluOp=10 funct3=000 is_rtype=1 funct7_5=1 a=3 b=3 -> result=0, zero=1.
REQ-033 SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU same operands -> result=0.
REQ-034 out_ready held low 5 cycles in DONE while in_valid pulses -> result stable, no acceptance, in_ready=0; out_ready high -> IDLE next cycle.
REQ-035 reset asserted mid-SHIFT (SLL b=20) -> next cycle IDLE, out_valid=0, result=0; aluOp=11 afterwards -> illegal=1, result=0, latency 1.
